// File: rtl/hilo_seq.sv
// hilo_seq: iterative HI/LO multiply/divide unit for the EXE stage.
// Signed/unsigned 32-iteration shift-add multiply and restoring divide.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b     request, operation (MULT/MULTU/DIV/DIVU), operands
//   flush               abort the current operation / suppress write-back
//   stall               holds IF/ID/EXE while a request is in flight
//   busy                state is not IDLE
//   done, hilo_wena     one-cycle result-valid pulse / HI,LO write enable
//   hi_wdata, lo_wdata  product high/low or remainder/quotient
module hilo_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            hilo_wena,
  output logic [XLEN-1:0] hi_wdata,
  output logic [XLEN-1:0] lo_wdata
);

  localparam int unsigned CW  = $clog2(XLEN);
  localparam int unsigned AW  = 2 * XLEN;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   acc_q;
  logic [XLEN-1:0] src_q;
  logic            is_div_q;
  logic            neg_q;
  logic            a_neg_q;
  logic            b_zero_q;

  logic            accept;
  logic            is_signed_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  logic [XLEN:0]   div_diff;
  logic [AW-1:0]   div_next;
  logic [AW-1:0]   acc_step;
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] hi_res;
  logic [XLEN-1:0] lo_res;

  // Operand decode: magnitudes and signs for the request at the input.
  always_comb begin
    accept       = 1'b0;
    is_signed_in = ~op[0];
    a_neg_in     = is_signed_in & a[XLEN-1];
    b_neg_in     = is_signed_in & b[XLEN-1];
    a_mag        = a_neg_in ? (~a + XLEN'(1)) : a;
    b_mag        = b_neg_in ? (~b + XLEN'(1)) : b;
    if (state_q == S_IDLE && start && !flush) begin
      accept = 1'b1;
    end
  end

  // One iteration step. Multiply: acc = {partial_hi, multiplier}, shift right
  // after conditional add. Divide: acc = {remainder, dividend/quotient},
  // shift left and keep the subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, src_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_diff = acc_q[AW-1:XLEN-1] - {1'b0, src_q};
    div_next = div_diff[XLEN] ? {acc_q[AW-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step = is_div_q ? div_next : mul_next;
  end

  // Sign correction of the final step; divide by zero forces an all-ones
  // quotient while the remainder already equals the original dividend.
  always_comb begin
    prod_fix = neg_q ? (~acc_step + AW'(1)) : acc_step;
    quo_fix  = acc_step[XLEN-1:0];
    if (b_zero_q) begin
      quo_fix = '1;
    end else if (neg_q) begin
      quo_fix = ~acc_step[XLEN-1:0] + XLEN'(1);
    end
    rem_fix  = a_neg_q ? (~acc_step[AW-1:XLEN] + XLEN'(1)) : acc_step[AW-1:XLEN];
    hi_res   = is_div_q ? rem_fix : prod_fix[AW-1:XLEN];
    lo_res   = is_div_q ? quo_fix : prod_fix[XLEN-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    hilo_wena = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // rst_n gating keeps stall low while reset holds the FSM in IDLE.
    stall     = rst_n & (accept | (state_q == S_RUN));
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) & ~flush;
    hilo_wena = done;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      src_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        is_div_q <= op[1];
        neg_q    <= a_neg_in ^ b_neg_in;
        a_neg_q  <= a_neg_in;
        b_zero_q <= (b == '0);
        src_q    <= op[1] ? b_mag : a_mag;
        acc_q    <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q + CW'(1);
        acc_q <= acc_step;
        if (cnt_q == LAST && !flush) begin
          hi_wdata <= hi_res;
          lo_wdata <= lo_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq: self-checking bench for hilo_seq with directed corner cases
// and randomized operations checked against an arithmetic reference model.
module tb_hilo_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic        hilo_wena;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int checks = 0;
  int errors = 0;
  int wena_cnt = 0;
  int exp_wena = 0;

  hilo_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hilo_wena (hilo_wena),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (hilo_wena === 1'b1) wena_cnt <= wena_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from the arithmetic definition of each operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return 64'(ux * uy);
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b11) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Issue one operation (caller is just past a negedge) and check latency,
  // stall length, results and the done pulse.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp,
                        input bit hold, input bit fdone);
    int n;
    int stall_cnt;
    bit in_done;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    chk({tag, "_stall0"}, 64'(stall), 64'd1);
    stall_cnt = 1;
    n = 1;
    in_done = 1'b0;
    while (n < 60 && !in_done) begin
      @(negedge clk);
      start = hold;
      op = 2'($urandom); a = $urandom; b = $urandom;
      n++;
      #1;
      if (busy && !stall) in_done = 1'b1;
      else if (stall) stall_cnt++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_stallcnt"}, 64'(stall_cnt), 64'd33);
    if (fdone) begin
      flush = 1'b1;
      #1;
      chk({tag, "_fdone"}, {62'h0, done, hilo_wena}, 64'h0);
    end else begin
      chk({tag, "_done"}, {62'h0, done, hilo_wena}, 64'h3);
      exp_wena++;
    end
    chk({tag, "_res"}, {hi_wdata, lo_wdata}, exp);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk({tag, "_idle"}, {62'h0, busy, done}, 64'h0);
    if (hold) chk({tag, "_hold_stall"}, 64'(stall), 64'd1);
    start = 1'b0;
    chk({tag, "_holdres"}, {hi_wdata, lo_wdata}, exp);
  endtask

  // Start an operation and stop at the negedge inside RUN with counter=k.
  task automatic start_to_cnt(input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y, input int k);
    start = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  logic [1:0]  ro;
  logic [31:0] ra, rb;
  int          w0;

  initial begin
    rst_n = 1'b0; start = 1'b1; op = 2'b00; a = '1; b = 32'd2; flush = 1'b0;
    #12;
    chk("rst_out", {59'h0, stall, busy, done, hilo_wena, 1'b0}, 64'h0);
    chk("rst_data", {hi_wdata, lo_wdata}, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_m7", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    @(negedge clk);
    w0 = wena_cnt;
    run_op("divu_z", 2'b11, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    chk("divu_z_once", 64'(wena_cnt - w0), 64'd1);
    run_op("div_z", 2'b10, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    run_op("hold", 2'b01, 32'd3, 32'd5, 64'd15, 1'b1, 1'b0);
    @(negedge clk);
    run_op("fdone", 2'b00, 32'd6, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 1'b1);

    // Flush mid-RUN, then an immediate new operation.
    @(negedge clk);
    start_to_cnt(2'b11, 32'd1000, 32'd7, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle", {62'h0, busy, stall}, 64'h0);
    run_op("after_flush", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
           64'h0B00_EA4E_242D_2080, 1'b0, 1'b0);

    // Reset mid-RUN: outputs clear immediately, no write follows.
    @(negedge clk);
    start_to_cnt(2'b00, 32'd9, 32'd9, 20);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("rst_mid_out", {60'h0, stall, busy, done, hilo_wena}, 64'h0);
    chk("rst_mid_data", {hi_wdata, lo_wdata}, 64'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) @(negedge clk);
    chk("rst_no_wena", 64'(wena_cnt), 64'(exp_wena));
    chk("rst_idle", 64'(busy), 64'd0);

    // First edge after reset release accepts start.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = -32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op("rand", ro, ra, rb, model(ro, ra, rb), 1'b0, 1'b0);
    end

    @(negedge clk);
    chk("wena_total", 64'(wena_cnt), 64'(exp_wena));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
